controlador_sap1: RTL



---
 rtl/controlador_sap1.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/controlador_sap1.sv
// ============================================================================
//  Module      : controlador_sap1
//  Description : SAP-1 control sequencer. A six-state ring (T1..T6) plus a
//                HALT state. A Moore decoder turns (state, opcode) into the
//                datapath control word.
//  Ports       : CLK      - system clock, rising-edge active
//                CLR_n    - asynchronous active-low clear
//                opcode   - instruction register bits [7:4]
//                t_state  - one-hot T-state (bit 0 = T1), zero while halted
//                Cp..Lo   - datapath increment/enable/load controls
//                HLT      - registered halt flag
//  Options     : SAP1_VARIABLE_CYCLE_EN - when defined, execute phases with
//                no remaining work are skipped (LDA 5, OUT 4, NOP 3 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controlador_sap1 (
  input  logic       CLK,
  input  logic       CLR_n,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm,
  output logic       CE,
  output logic       Li,
  output logic       Ei,
  output logic       La,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb,
  output logic       Lo,
  output logic       HLT
);

  localparam logic [2:0] S_T1   = 3'd0;
  localparam logic [2:0] S_T2   = 3'd1;
  localparam logic [2:0] S_T3   = 3'd2;
  localparam logic [2:0] S_T4   = 3'd3;
  localparam logic [2:0] S_T5   = 3'd4;
  localparam logic [2:0] S_T6   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word bit positions: {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
  localparam int B_CP = 11;
  localparam int B_EP = 10;
  localparam int B_LM = 9;
  localparam int B_CE = 8;
  localparam int B_LI = 7;
  localparam int B_EI = 6;
  localparam int B_LA = 5;
  localparam int B_EA = 4;
  localparam int B_SU = 3;
  localparam int B_EU = 2;
  localparam int B_LB = 1;
  localparam int B_LO = 0;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic        hlt_q;
  logic [11:0] ctrl;
  logic        op_is_nop;

  assign op_is_nop = (opcode != OP_LDA) && (opcode != OP_ADD) &&
                     (opcode != OP_SUB) && (opcode != OP_OUT) &&
                     (opcode != OP_HLT);

  // --------------------------------------------------------------------------
  // State register. HLT is its own flop, set on the edge that enters HALT.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state <= S_T1;
      hlt_q <= 1'b0;
    end else begin
      state <= state_next;
      hlt_q <= (state_next == S_HALT);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. opcode only matters from T3 onward (T3 only in the
  // variable-cycle build, where a NOP can return straight to T1).
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_T1: state_next = S_T2;
      S_T2: state_next = S_T3;
`ifdef SAP1_VARIABLE_CYCLE_EN
      S_T3: state_next = op_is_nop ? S_T1 : S_T4;
      S_T4: begin
        if (opcode == OP_HLT)      state_next = S_HALT;
        else if (opcode == OP_OUT) state_next = S_T1;
        else                       state_next = S_T5;
      end
      S_T5: state_next = (opcode == OP_LDA) ? S_T1 : S_T6;
`else
      S_T3: state_next = S_T4;
      S_T4: state_next = (opcode == OP_HLT) ? S_HALT : S_T5;
      S_T5: state_next = S_T6;
`endif
      S_T6:    state_next = S_T1;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_T1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode. Controls are gated by CLR_n so that nothing reaches the
  // datapath while clear is held, yet T1's decode appears the moment it lifts.
  // --------------------------------------------------------------------------
  always_comb begin
    t_state = 6'b000000;
    ctrl    = '0;
    case (state)
      S_T1: begin
        t_state    = 6'b000001;
        ctrl[B_EP] = 1'b1;
        ctrl[B_LM] = 1'b1;
      end
      S_T2: begin
        t_state    = 6'b000010;
        ctrl[B_CP] = 1'b1;
      end
      S_T3: begin
        t_state    = 6'b000100;
        ctrl[B_CE] = 1'b1;
        ctrl[B_LI] = 1'b1;
      end
      S_T4: begin
        t_state = 6'b001000;
        if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl[B_EI] = 1'b1;
          ctrl[B_LM] = 1'b1;
        end else if (opcode == OP_OUT) begin
          ctrl[B_EA] = 1'b1;
          ctrl[B_LO] = 1'b1;
        end
      end
      S_T5: begin
        t_state = 6'b010000;
        if (opcode == OP_LDA) begin
          ctrl[B_CE] = 1'b1;
          ctrl[B_LA] = 1'b1;
        end else if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl[B_CE] = 1'b1;
          ctrl[B_LB] = 1'b1;
        end
      end
      S_T6: begin
        t_state = 6'b100000;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl[B_EU] = 1'b1;
          ctrl[B_LA] = 1'b1;
          ctrl[B_SU] = (opcode == OP_SUB);
        end
      end
      default: begin
        t_state = 6'b000000;
        ctrl    = '0;
      end
    endcase
    if (!CLR_n) begin
      ctrl = '0;
    end
  end

  assign {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo} = ctrl;
  assign HLT = hlt_q;

endmodule

`default_nettype wire
